// File: rtl/spi_session_pkg.sv
// Shared definitions for the SPI session master: FSM state encoding,
// default frame length and a small sizing helper.
package spi_session_pkg;

   localparam int FRAME_BITS_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_e;

   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI serial clock divider: toggles sclk_o every CLK_HALF enabled cycles and
// flags the cycle before each rising/falling edge so the master can act on it.
module spi_clk_gen #(
   parameter int CLK_HALF = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic rise_o,
   output logic fall_o,
   output logic sclk_o
);

   localparam int HC_W = $clog2(CLK_HALF + 1);
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_HALF - 1);

   logic [HC_W-1:0] hcnt_q, hcnt_d;
   logic            sclk_q, sclk_d;
   logic            tick;

   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      tick   = en_i && (hcnt_q == HC_LAST);
      rise_o = tick && !sclk_q;
      fall_o = tick && sclk_q;
      hcnt_d = hcnt_q;
      sclk_d = sclk_q;
      if (!en_i) begin
         hcnt_d = '0;
         sclk_d = 1'b0;
      end else if (tick) begin
         hcnt_d = '0;
         sclk_d = !sclk_q;
      end else begin
         hcnt_d = hcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: registers use non-blocking assignments so every flop sees pre-edge values.
      if (rst_i) begin
         hcnt_q <= '0;
         sclk_q <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_session_master.sv
// SPI mode-0 session master: one START runs CS setup, FRAME_BITS clock periods,
// CS hold and an inter-session gap. Optional SPI_SESSION_REPEAT_EN adds REPEAT.
module spi_session_master
   import spi_session_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int CLK_HALF   = 5,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 1,
   parameter int GAP        = 15
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [FRAME_BITS-1:0] TXDATA,
`ifdef SPI_SESSION_REPEAT_EN
   input  logic [3:0]            REPEAT,
`endif
   output logic                  BUSY,
   output logic                  DONE,
   output logic [FRAME_BITS-1:0] RXDATA,
   output logic                  SPI_CS,
   output logic                  SPI_CLK,
   output logic                  SPI_MOSI,
   input  logic                  SPI_MISO
);

   localparam int BIT_W = $clog2(FRAME_BITS + 1);
   localparam int TMR_W = $clog2(max_of3(CS_SETUP, CS_HOLD, GAP) + 1);

   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
   localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((GAP > 0) ? GAP - 1 : 0);

   state_e                  state_q, state_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [FRAME_BITS-1:0]   tx_q, tx_d;
   logic [FRAME_BITS-1:0]   rx_q, rx_d;
   logic [FRAME_BITS-1:0]   rxdata_q, rxdata_d;
   logic                    cs_q, cs_d;
   logic                    mosi_q, mosi_d;
   logic                    done_q, done_d;
   logic                    session_end;
`ifdef SPI_SESSION_REPEAT_EN
   logic [FRAME_BITS-1:0]   word_q, word_d;
   logic [3:0]              rep_q, rep_d;
`endif

   logic sclk_en, sclk_rise, sclk_fall;

   assign sclk_en = (state_q == ST_SHIFT);

   spi_clk_gen #(
      .CLK_HALF (CLK_HALF)
   ) u_clk_gen (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (sclk_en),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall),
      .sclk_o (SPI_CLK)
   );

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      bit_d       = bit_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rxdata_d    = rxdata_q;
      cs_d        = cs_q;
      mosi_d      = mosi_q;
      done_d      = 1'b0;
      session_end = 1'b0;
`ifdef SPI_SESSION_REPEAT_EN
      word_d      = word_q;
      rep_d       = rep_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_SETUP;
               tx_d    = TXDATA;
               mosi_d  = TXDATA[FRAME_BITS-1];
               cs_d    = 1'b0;
               tmr_d   = '0;
`ifdef SPI_SESSION_REPEAT_EN
               word_d  = TXDATA;
               rep_d   = REPEAT;
`endif
            end
         end

         ST_SETUP: begin
            if (tmr_q == SETUP_LAST) begin
               state_d = ST_SHIFT;
               tmr_d   = '0;
               bit_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         ST_SHIFT: begin
            // MISO is captured on the rise; MOSI only moves on falls so it is stable at every rise.
            if (sclk_rise) begin
               rx_d = (rx_q << 1) | FRAME_BITS'(SPI_MISO);
            end
            if (sclk_fall) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  mosi_d  = 1'b0;
                  state_d = ST_HOLD;
                  tmr_d   = '0;
               end else begin
                  tx_d   = tx_q << 1;
                  mosi_d = tx_d[FRAME_BITS-1];
               end
            end
         end

         ST_HOLD: begin
            if (tmr_q == HOLD_LAST) begin
               tmr_d    = '0;
               cs_d     = 1'b1;
               done_d   = 1'b1;
               rxdata_d = rx_q;
               if (GAP == 0) begin
                  state_d     = ST_IDLE;
                  session_end = 1'b1;
               end else begin
                  state_d = ST_GAP;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         ST_GAP: begin
            if (tmr_q == GAP_LAST) begin
               tmr_d       = '0;
               state_d     = ST_IDLE;
               session_end = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

`ifdef SPI_SESSION_REPEAT_EN
      // Restart from the latched word instead of returning to IDLE.
      if (session_end && (rep_q != 4'd0)) begin
         state_d = ST_SETUP;
         tx_d    = word_q;
         mosi_d  = word_q[FRAME_BITS-1];
         cs_d    = 1'b0;
         tmr_d   = '0;
         rep_d   = rep_q - 4'd1;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         tmr_q    <= '0;
         bit_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         rxdata_q <= '0;
         cs_q     <= 1'b1;
         mosi_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SPI_SESSION_REPEAT_EN
         word_q   <= '0;
         rep_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         rxdata_q <= rxdata_d;
         cs_q     <= cs_d;
         mosi_q   <= mosi_d;
         done_q   <= done_d;
`ifdef SPI_SESSION_REPEAT_EN
         word_q   <= word_d;
         rep_q    <= rep_d;
`endif
      end
   end

   assign BUSY     = (state_q != ST_IDLE);
   assign DONE     = done_q;
   assign RXDATA   = rxdata_q;
   assign SPI_CS   = cs_q;
   assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_session_master.sv
// Bench for spi_session_master: default instance (64-bit frame) and a fast
// 8-bit instance, driven by a mode-0 slave model with timing from the session rules.
module tb_spi_session_master;

   localparam int A_N = 64, A_H = 5, A_SETUP = 2, A_HOLD = 1, A_GAP = 15;
   localparam int B_N = 8,  B_H = 1, B_SETUP = 2, B_HOLD = 1, B_GAP = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, miso;
   logic        start_a, start_b;
   logic [63:0] txd_a;
   logic [7:0]  txd_b;
   logic        busy_a, done_a, cs_a, sclk_a, mosi_a;
   logic        busy_b, done_b, cs_b, sclk_b, mosi_b;
   logic [63:0] rx_a;
   logic [7:0]  rx_b;
`ifdef SPI_SESSION_REPEAT_EN
   logic [3:0]  rep_a, rep_b;
`endif

   int checks = 0;
   int errors = 0;

   spi_session_master u_dut_a (
      .CLK      (clk),
      .RST      (rst),
      .START    (start_a),
      .TXDATA   (txd_a),
`ifdef SPI_SESSION_REPEAT_EN
      .REPEAT   (rep_a),
`endif
      .BUSY     (busy_a),
      .DONE     (done_a),
      .RXDATA   (rx_a),
      .SPI_CS   (cs_a),
      .SPI_CLK  (sclk_a),
      .SPI_MOSI (mosi_a),
      .SPI_MISO (miso)
   );

   spi_session_master #(
      .FRAME_BITS (B_N),
      .CLK_HALF   (B_H),
      .GAP        (B_GAP)
   ) u_dut_b (
      .CLK      (clk),
      .RST      (rst),
      .START    (start_b),
      .TXDATA   (txd_b),
`ifdef SPI_SESSION_REPEAT_EN
      .REPEAT   (rep_b),
`endif
      .BUSY     (busy_b),
      .DONE     (done_b),
      .RXDATA   (rx_b),
      .SPI_CS   (cs_b),
      .SPI_CLK  (sclk_b),
      .SPI_MOSI (mosi_b),
      .SPI_MISO (miso)
   );

   // Monitor view of whichever instance is under test.
   logic        msel;
   logic        m_cs, m_sclk, m_mosi, m_busy, m_done;
   logic [63:0] m_rx;
   assign m_cs   = msel ? cs_b   : cs_a;
   assign m_sclk = msel ? sclk_b : sclk_a;
   assign m_mosi = msel ? mosi_b : mosi_a;
   assign m_busy = msel ? busy_b : busy_a;
   assign m_done = msel ? done_b : done_a;
   assign m_rx   = msel ? {56'd0, rx_b} : rx_a;

   // Runs reps+1 sessions from one START; k counts edges after the START edge.
   task automatic run_session(input string name, input logic b_sel, input logic [63:0] tx,
                              input logic [63:0] pat, input int reps, input int retrig_k);
      int n, h, setup, hold, gap, sess_len, done_k, end_k;
      int rises, falls, dones, done_bad, per_bad, mosi_bad, last_rise, idle_at;
      logic [63:0] mask, mosi_seen, rx_done;
      logic prev_clk, prev_mosi;
      n     = b_sel ? B_N : A_N;
      h     = b_sel ? B_H : A_H;
      setup = b_sel ? B_SETUP : A_SETUP;
      hold  = b_sel ? B_HOLD : A_HOLD;
      gap   = b_sel ? B_GAP : A_GAP;
      mask  = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      sess_len = 1 + setup + 2 * h * n + hold + gap;
      done_k   = setup + 2 * h * n + hold;
      end_k    = (reps + 1) * (sess_len - 1);
      rises = 0; falls = 0; dones = 0; done_bad = 0; per_bad = 0; mosi_bad = 0;
      last_rise = -1; idle_at = -1; mosi_seen = '0; rx_done = '0;
      prev_clk = 1'b0; prev_mosi = 1'b0;

      @(negedge clk);
      msel = b_sel;
      miso = pat[n-1];
      if (b_sel) begin
         txd_b = tx[7:0]; start_b = 1'b1;
      end else begin
         txd_a = tx; start_a = 1'b1;
`ifdef SPI_SESSION_REPEAT_EN
         rep_a = 4'(reps);
`endif
      end

      for (int k = 0; k <= end_k + 8; k++) begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         if (k == 0) begin
            checks++;
            if ({m_cs, m_busy, m_mosi} !== {1'b0, 1'b1, tx[n-1]}) begin
               errors++;
               $display("FAIL %s start edge {cs,busy,mosi}: got %b expected %b", name,
                        {m_cs, m_busy, m_mosi}, {1'b0, 1'b1, tx[n-1]});
            end
         end
         if (k == retrig_k) begin
            if (b_sel) begin start_b = 1'b1; txd_b = ~txd_b; end
            else begin start_a = 1'b1; txd_a = ~txd_a; end
         end
         if (m_cs) begin
            falls = 0; miso = pat[n-1]; last_rise = -1;
         end else if (m_sclk && !prev_clk) begin
            rises++;
            if (last_rise >= 0 && (k - last_rise) != 2 * h) per_bad++;
            last_rise = k;
            if (m_mosi !== prev_mosi) mosi_bad++;
            mosi_seen = {mosi_seen[62:0], m_mosi};
         end else if (!m_sclk && prev_clk) begin
            falls++;
            miso = (falls < n) ? pat[n-1-falls] : 1'b0;
         end
         if (m_done) begin
            if (k != done_k + dones * (sess_len - 1)) done_bad++;
            dones++;
            rx_done = m_rx;
         end
         if (!m_busy && idle_at < 0) idle_at = k;
         prev_clk  = m_sclk;
         prev_mosi = m_mosi;
      end

      checks++;
      if (rises !== n * (reps + 1)) begin
         errors++; $display("FAIL %s sclk rises: got %0d expected %0d", name, rises, n * (reps + 1));
      end
      checks++;
      if (per_bad !== 0) begin
         errors++; $display("FAIL %s sclk period: %0d periods differ from %0d cycles", name, per_bad, 2 * h);
      end
      checks++;
      if (mosi_bad !== 0) begin
         errors++; $display("FAIL %s mosi stability: %0d rises with changing mosi", name, mosi_bad);
      end
      checks++;
      if ((mosi_seen & mask) !== (tx & mask)) begin
         errors++; $display("FAIL %s mosi bits: got %h expected %h", name, mosi_seen & mask, tx & mask);
      end
      checks++;
      if (dones !== reps + 1) begin
         errors++; $display("FAIL %s done pulses: got %0d expected %0d", name, dones, reps + 1);
      end
      checks++;
      if (done_bad !== 0) begin
         errors++; $display("FAIL %s done timing: %0d pulses off expected cycle (first %0d)", name, done_bad, done_k);
      end
      checks++;
      if (idle_at !== end_k) begin
         errors++; $display("FAIL %s busy clear: got k=%0d expected k=%0d", name, idle_at, end_k);
      end
      checks++;
      if ((rx_done & mask) !== (pat & mask)) begin
         errors++; $display("FAIL %s rxdata at done: got %h expected %h", name, rx_done & mask, pat & mask);
      end
      checks++;
      if ((m_rx & mask) !== (pat & mask)) begin
         errors++; $display("FAIL %s rxdata hold: got %h expected %h", name, m_rx & mask, pat & mask);
      end
`ifdef SPI_SESSION_REPEAT_EN
      rep_a = 4'd0;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; miso = 1'b0;
      txd_a = '0; txd_b = '0; msel = 1'b0;
`ifdef SPI_SESSION_REPEAT_EN
      rep_a = 4'd0; rep_b = 4'd0;
`endif
      repeat (3) @(negedge clk);
      checks++;
      if ({cs_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin
         errors++; $display("FAIL reset A {cs,sclk,mosi,busy,done}: got %b expected 10000",
                            {cs_a, sclk_a, mosi_a, busy_a, done_a});
      end
      checks++;
      if (rx_a !== 64'd0) begin
         errors++; $display("FAIL reset A rxdata: got %h expected 0", rx_a);
      end
      checks++;
      if ({cs_b, sclk_b, mosi_b, busy_b, done_b} !== 5'b10000) begin
         errors++; $display("FAIL reset B {cs,sclk,mosi,busy,done}: got %b expected 10000",
                            {cs_b, sclk_b, mosi_b, busy_b, done_b});
      end
      checks++;
      if (rx_b !== 8'd0) begin
         errors++; $display("FAIL reset B rxdata: got %h expected 0", rx_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_abort();
      int rises, dones;
      logic prev, hit;
      @(negedge clk);
      msel = 1'b0; miso = 1'b1;
      txd_a = {$urandom(), $urandom()}; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      rises = 0; prev = 1'b0; hit = 1'b0;
      for (int k = 0; k < 1000 && !hit; k++) begin
         @(negedge clk);
         if (sclk_a && !prev) rises++;
         prev = sclk_a;
         if (rises == 30) hit = 1'b1;
      end
      checks++;
      if (hit !== 1'b1) begin
         errors++; $display("FAIL abort 30th rise: got %0d rises expected 30", rises);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({cs_a, sclk_a, busy_a, done_a} !== 4'b1000) begin
         errors++; $display("FAIL abort next edge {cs,sclk,busy,done}: got %b expected 1000",
                            {cs_a, sclk_a, busy_a, done_a});
      end
      rst = 1'b0;
      dones = 0;
      repeat (700) begin
         @(negedge clk);
         if (done_a) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++; $display("FAIL abort done pulses: got %0d expected 0", dones);
      end
      checks++;
      if ({busy_a, cs_a, rx_a} !== {1'b0, 1'b1, 64'd0}) begin
         errors++; $display("FAIL abort idle/rxdata: got busy=%b cs=%b rx=%h expected busy=0 cs=1 rx=0",
                            busy_a, cs_a, rx_a);
      end
   endtask

   task automatic test_known_frame();
      run_session("known_frame", 1'b0, 64'h0800_0001_0000_0000, 64'hA5A5_0F0F_1234_CDEF, 0, -1);
   endtask

   task automatic test_retrigger();
      run_session("retrigger", 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0, A_SETUP + 99);
   endtask

   task automatic test_random();
      for (int i = 0; i < 2; i++)
         run_session("random_a", 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_session("fast_b", 1'b1, {56'd0, 8'($urandom())}, {56'd0, 8'($urandom())}, 0, -1);
   endtask

`ifdef SPI_SESSION_REPEAT_EN
   task automatic test_repeat();
      run_session("repeat", 1'b0, {$urandom(), $urandom()}, 64'hA5A5_0F0F_1234_CDEF, 2, -1);
   endtask
`endif

   initial begin
      test_reset();
      test_reset_abort();
      test_known_frame();
      test_retrigger();
      test_random();
      test_back_to_back();
`ifdef SPI_SESSION_REPEAT_EN
      test_repeat();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_session_master.md
SPI_SESSION_MASTER -- requirements
Module: spi_session_master

Interface
- REQ-001 SHALL have parameter FRAME_BITS, default 64: bits per SPI session.
- REQ-002 SHALL have parameter CLK_HALF, default 5: CLK cycles per SPI_CLK half-period (min 1).
- REQ-003 SHALL have parameter CS_SETUP, default 2: CLK cycles from SPI_CS fall to the first SPI_CLK rise (min 1).
- REQ-004 SHALL have parameter CS_HOLD, default 1: CLK cycles from the last SPI_CLK fall to SPI_CS rise (min 1).
- REQ-005 SHALL have parameter GAP, default 15: CLK cycles SPI_CS stays high after a session before BUSY clears (min 0).
- REQ-006 SHALL have the following ports, clock and reset first:
  - CLK  in  1  system clock; all logic on its rising edge.
  - RST  in  1  synchronous, active-high reset.
  - START  in  1  session request.
  - TXDATA  in  FRAME_BITS  command word; bit FRAME_BITS-1 is sent first.
  - BUSY  out  1  session in progress.
  - DONE  out  1  one-cycle completion pulse.
  - RXDATA  out  FRAME_BITS  captured MISO word; first bit received lands in the MSB.
  - SPI_CS  out  1  active-low chip select.
  - SPI_CLK  out  1  serial clock; idles low.
  - SPI_MOSI  out  1  serial data to the sensor.
  - SPI_MISO  in  1  serial data from the sensor.

Function
- REQ-007 SHALL implement the states IDLE, SETUP, SHIFT, HOLD and GAP.
- REQ-008 In IDLE, START=1 SHALL latch TXDATA into the TX shift register and enter SETUP on the next edge; SPI_CS=0, BUSY=1 and SPI_MOSI=TXDATA[FRAME_BITS-1] SHALL be visible on that same edge.
- REQ-009 START while BUSY=1 SHALL be ignored, with no queuing.
- REQ-010 SETUP SHALL last exactly CS_SETUP cycles, then enter SHIFT with SPI_CLK still low.
- REQ-011 SHIFT SHALL toggle SPI_CLK every CLK_HALF cycles and produce exactly FRAME_BITS full periods (rise, then fall).
- REQ-012 On each SPI_CLK rise, SPI_MISO SHALL be shifted into the RX shift register at the LSB.
- REQ-013 On each SPI_CLK fall except the last, SPI_MOSI SHALL advance to the next lower TX bit; SPI_MOSI SHALL be stable across every rising edge.
- REQ-014 After the FRAME_BITS-th fall, SPI_MOSI SHALL go to 0 and the block SHALL enter HOLD with SPI_CLK low.
- REQ-015 HOLD SHALL last CS_HOLD cycles; on exit, SPI_CS SHALL go to 1, RXDATA SHALL load from the RX shift register, and DONE SHALL pulse for exactly 1 cycle.
- REQ-016 GAP SHALL last GAP cycles with BUSY=1; then the block SHALL return to IDLE with BUSY=0. If GAP=0, BUSY SHALL clear in the same cycle DONE pulses.
- REQ-017 Total session length SHALL be 1 + CS_SETUP + 2·CLK_HALF·FRAME_BITS + CS_HOLD + GAP cycles from the START edge to BUSY=0.
- REQ-018 The bit counter SHALL be $clog2(FRAME_BITS+1) bits wide, and the half-period counter $clog2(CLK_HALF+1) bits wide; neither SHALL wrap inside a session.
- REQ-019 RXDATA SHALL hold its value until the next session completes.

Reset
- REQ-020 RST=1 SHALL force IDLE on the next CLK edge from any state, including mid-SHIFT.
- REQ-021 Reset values SHALL be: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, BUSY=0, DONE=0, RXDATA=0; all counters and shift registers 0.
- REQ-022 A session aborted by reset SHALL NOT pulse DONE and SHALL NOT update RXDATA.

Configuration
- REQ-023 Macro SPI_SESSION_REPEAT_EN defined: adds input REPEAT[3:0]. One START SHALL run REPEAT+1 back-to-back sessions with the same latched TXDATA, each separated by GAP. DONE SHALL pulse after every session, RXDATA SHALL update each time, and BUSY SHALL stay high until the last GAP ends.
- REQ-024 Macro SPI_SESSION_REPEAT_EN undefined: the REPEAT port SHALL be absent, and one START SHALL produce exactly one session.

Structure
- REQ-025 Shared package spi_session_pkg SHALL hold the state enum (IDLE, SETUP, SHIFT, HOLD, GAP) and the FRAME_BITS default constant.
- REQ-026 The SPI_CLK half-period divider SHALL be the single sub-module spi_clk_gen, with an enable input, a rise-strobe output, a fall-strobe output and the SPI_CLK output.

Verification
- REQ-027 Defaults, TXDATA=64'h0800_0001_0000_0000, START pulse -> a slave model sees 1s only at bit 59 (5th rise) and bit 32 (32nd rise); exactly 64 SPI_CLK rises; DONE at cycle 1+2+640+1.
- REQ-028 Slave model drives MISO pattern 64'hA5A5_0F0F_1234_CDEF -> RXDATA equals that pattern when DONE pulses.
- REQ-029 START re-asserted at the 100th SHIFT cycle -> no effect; exactly one DONE per session.
- REQ-030 RST asserted at the 30th SPI_CLK rise -> next edge SPI_CS=1, SPI_CLK=0, no DONE, RXDATA unchanged.
- REQ-031 With SPI_SESSION_REPEAT_EN and REPEAT=2 -> three sessions, three DONE pulses, each session separated by 15 cycles of SPI_CS high; BUSY falls only after the third GAP.
- REQ-032 CLK_HALF=1, FRAME_BITS=8, GAP=0 -> SPI_CLK period of 2 cycles, 8 rises, BUSY clears in the DONE cycle.
